// File: rtl/pdm_dual_tx.sv
// pdm_dual_tx: stereo PDM microphone-pair emulator.
// Takes signed PCM sample pairs over a valid/ready handshake, runs a
// first-order sigma-delta modulator per channel and drives both channels on
// one DDR line: channel 0 while pdm_clk is high, channel 1 while it is low.
module pdm_dual_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 2,
    parameter int DECIM   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pcm_valid,
    output logic              pcm_ready,
    input  logic [DATA_W-1:0] pcm_data_0,
    input  logic [DATA_W-1:0] pcm_data_1,
    output logic              pdm_clk,
    output logic              ddr_data,
    output logic              underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRM_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [DIV_W-1:0]  DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FRM_W-1:0]  FRM_ZERO = {FRM_W{1'b0}};
    localparam logic [FRM_W-1:0]  FRM_ONE  = FRM_W'(1);
    localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(DECIM - 1);
    localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One modulator step: offset-binary sample added to the accumulator.
    // The carry out is the PDM bit, the low DATA_W bits the new accumulator.
    function automatic logic [DATA_W:0] mod_sum(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] x);
        return {1'b0, acc} + {1'b0, x ^ SIGN_BIT};
    endfunction

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              phase_q, phase_d;          // 0 = LOW half, 1 = HIGH half
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic [DATA_W-1:0] act0_q, act0_d, act1_q, act1_d;
    logic [DATA_W-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic              hold_full_q, hold_full_d;
    logic              bit1_q, bit1_d;
    logic              pdm_clk_q, pdm_clk_d;
    logic              ddr_data_q, ddr_data_d;
    logic              underrun_q, underrun_d;

    logic              xfer_s;
    logic              rise_s;
    logic              fall_s;
    logic              boundary_s;
    logic              bypass_s;
    logic [DATA_W:0]   sum0_s, sum1_s;

    assign xfer_s    = pcm_valid & ~hold_full_q;
    assign pcm_ready = ~hold_full_q;
    assign pdm_clk   = pdm_clk_q;
    assign ddr_data  = ddr_data_q;
    assign underrun  = underrun_q;

    // Next-state logic: clock divider, phase sequencing, sample buffering, modulator.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        phase_d     = phase_q;
        frame_cnt_d = frame_cnt_q;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        act0_d      = act0_q;
        act1_d      = act1_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        hold_full_d = hold_full_q;
        bit1_d      = bit1_q;
        pdm_clk_d   = pdm_clk_q;
        ddr_data_d  = ddr_data_q;
        underrun_d  = 1'b0;
        rise_s      = 1'b0;
        fall_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pdm_clk_d  = 1'b0;
                ddr_data_d = 1'b0;
                if (enable) begin
                    state_d     = ST_RUN;
                    div_cnt_d   = DIV_ZERO;
                    phase_d     = 1'b0;
                    frame_cnt_d = FRM_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = DIV_ZERO;
                    phase_d   = ~phase_q;
                    if (phase_q) begin
                        fall_s = 1'b1;
                    end else begin
                        rise_s = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        boundary_s = rise_s & (frame_cnt_q == FRM_ZERO);
        bypass_s   = boundary_s & ~hold_full_q & xfer_s;

        // A boundary drains the holding register first; an input arriving
        // exactly on an empty-holding boundary goes straight to active.
        if (boundary_s && hold_full_q) begin
            act0_d      = hold0_q;
            act1_d      = hold1_q;
            hold_full_d = 1'b0;
        end else if (bypass_s) begin
            act0_d = pcm_data_0;
            act1_d = pcm_data_1;
        end else if (xfer_s) begin
            hold0_d     = pcm_data_0;
            hold1_d     = pcm_data_1;
            hold_full_d = 1'b1;
        end else begin
            hold_full_d = hold_full_q;
        end

        underrun_d = boundary_s & ~hold_full_q & ~xfer_s;

        // The modulator always sees the post-load sample.
        sum0_s = mod_sum(acc0_q, act0_d);
        sum1_s = mod_sum(acc1_q, act1_d);

        if (rise_s) begin
            pdm_clk_d   = 1'b1;
            ddr_data_d  = sum0_s[DATA_W];
            bit1_d      = sum1_s[DATA_W];
            acc0_d      = sum0_s[DATA_W-1:0];
            acc1_d      = sum1_s[DATA_W-1:0];
            frame_cnt_d = (frame_cnt_q == FRM_LAST) ? FRM_ZERO : (frame_cnt_q + FRM_ONE);
        end else if (fall_s) begin
            pdm_clk_d = 1'b0;
            if (enable) begin
                ddr_data_d = bit1_q;
            end else begin
                ddr_data_d = 1'b0;
                state_d    = ST_IDLE;
            end
        end else begin
            acc0_d = acc0_q;
        end
    end

    // State register with synchronous reset; a pending holding sample is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= DIV_ZERO;
            phase_q     <= 1'b0;
            frame_cnt_q <= FRM_ZERO;
            acc0_q      <= {DATA_W{1'b0}};
            acc1_q      <= {DATA_W{1'b0}};
            act0_q      <= {DATA_W{1'b0}};
            act1_q      <= {DATA_W{1'b0}};
            hold0_q     <= {DATA_W{1'b0}};
            hold1_q     <= {DATA_W{1'b0}};
            hold_full_q <= 1'b0;
            bit1_q      <= 1'b0;
            pdm_clk_q   <= 1'b0;
            ddr_data_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            act0_q      <= act0_d;
            act1_q      <= act1_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            hold_full_q <= hold_full_d;
            bit1_q      <= bit1_d;
            pdm_clk_q   <= pdm_clk_d;
            ddr_data_q  <= ddr_data_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pdm_dual_tx.sv
// Testbench for pdm_dual_tx: a period-level reference model predicts every
// pdm_clk transition with its expected data bit; a monitor pops and compares.
module tb_pdm_dual_tx;

    localparam int DW  = 16;
    localparam int CD  = 2;
    localparam int DEC = 4;
    localparam int FULL = 1 << DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          pcm_valid = 1'b0;
    logic [DW-1:0] pcm_data_0 = '0;
    logic [DW-1:0] pcm_data_1 = '0;
    logic          pcm_ready, pdm_clk, ddr_data, underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pdm_dual_tx #(.DATA_W(DW), .CLK_DIV(CD), .DECIM(DEC)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .pcm_data_0(pcm_data_0), .pcm_data_1(pcm_data_1),
        .pdm_clk(pdm_clk), .ddr_data(ddr_data), .underrun(underrun)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int at; logic [DW-1:0] d0; logic [DW-1:0] d1; } xf_t;
    typedef struct { int at; bit rise; bit val; } ev_t;

    xf_t xq[$];      // accepted transfers, tagged with the clk edge they happen on
    ev_t exp_q[$];   // predicted pdm_clk transitions
    int  obs0[$];    // observed ch0 bits (sampled after each rise)
    int  obs1[$];    // observed ch1 bits (sampled after each fall)

    // Reference model state
    int            cyc = 0;
    bit            m_rst = 1'b1, m_run = 1'b0, m_hold_v = 1'b0;
    logic [DW-1:0] m_hold0, m_hold1, m_act0 = '0, m_act1 = '0;
    int            acc0 = 0, acc1 = 0, e0 = 0, k = 0;
    bit            m_b1 = 1'b0, exp_uf = 1'b0, exp_ready = 1'b1;
    int            uf_cnt = 0;

    // Reference model: periods counted from the enable edge, one sample pair per DECIM periods.
    always @(posedge clk) begin : model
        xf_t xf; bit arr_v; logic [DW-1:0] a0, a1; int t, s0, s1; bit b0;
        cyc++;
        arr_v = 1'b0; a0 = '0; a1 = '0;
        while (xq.size() > 0 && xq[0].at <= cyc) begin
            xf = xq.pop_front();
            if (xf.at == cyc) begin arr_v = 1'b1; a0 = xf.d0; a1 = xf.d1; end
        end
        exp_uf = 1'b0;
        if (rst) begin
            m_rst = 1'b1; m_run = 1'b0; m_hold_v = 1'b0; k = 0;
            acc0 = 0; acc1 = 0; m_act0 = '0; m_act1 = '0; m_b1 = 1'b0;
            exp_q.delete();
        end else begin
            m_rst = 1'b0;
            if (!m_run) begin
                if (enable) begin m_run = 1'b1; e0 = cyc; k = 0; end
            end else begin
                t = cyc - e0;
                if (t % (2*CD) == CD) begin
                    if (k % DEC == 0) begin
                        if (m_hold_v) begin m_act0 = m_hold0; m_act1 = m_hold1; m_hold_v = 1'b0; end
                        else if (arr_v) begin m_act0 = a0; m_act1 = a1; arr_v = 1'b0; end
                        else exp_uf = 1'b1;
                    end
                    // offset-binary value u in [0, 2^DW); carry out of acc+u is the bit
                    s0 = acc0 + int'($signed(m_act0)) + FULL/2;
                    s1 = acc1 + int'($signed(m_act1)) + FULL/2;
                    b0 = (s0 >= FULL); m_b1 = (s1 >= FULL);
                    acc0 = s0 % FULL; acc1 = s1 % FULL;
                    exp_q.push_back('{cyc, 1'b1, b0});
                end else if (t % (2*CD) == 0) begin
                    exp_q.push_back('{cyc, 1'b0, enable ? m_b1 : 1'b0});
                    k++;
                    if (!enable) begin m_run = 1'b0; k = 0; end
                end
            end
            if (arr_v) begin m_hold_v = 1'b1; m_hold0 = a0; m_hold1 = a1; end
        end
        exp_ready = !m_hold_v;
    end

    bit prev_pdm = 1'b0, prev_ddr = 1'b0;

    // Monitor: compares every DUT output against the model away from the active edge.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (m_rst) begin
            chk("rst_pdm_clk", pdm_clk, 0);
            chk("rst_ddr_data", ddr_data, 0);
            chk("rst_pcm_ready", pcm_ready, 1);
            chk("rst_underrun", underrun, 0);
            prev_pdm = 1'b0; prev_ddr = 1'b0;
        end else begin
            if (pdm_clk !== prev_pdm) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_edge", pdm_clk, prev_pdm);
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_time", cyc, e.at);
                    chk("edge_dir", pdm_clk, e.rise);
                    chk(e.rise ? "ch0_bit" : "ch1_bit", ddr_data, e.val);
                end
                if (pdm_clk === 1'b1) obs0.push_back(int'(ddr_data));
                else obs1.push_back(int'(ddr_data));
            end else begin
                chk("ddr_stable", ddr_data, prev_ddr);
                if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missed_edge", cyc, e.at - 1);
                end
            end
            prev_pdm = pdm_clk; prev_ddr = ddr_data;
            chk("underrun", underrun, exp_uf);
            chk("pcm_ready", pcm_ready, exp_ready);
            if (underrun === 1'b1) uf_cnt++;
        end
    end

    task automatic offer(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int n = 0;
        pcm_valid = 1'b1; pcm_data_0 = d0; pcm_data_1 = d1;
        while (pcm_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (pcm_ready === 1'b1) begin
            xq.push_back('{cyc + 1, d0, d1});
            @(negedge clk);
        end else begin
            chk("send_timeout", pcm_ready, 1);
        end
        pcm_valid = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge clk);
        offer(d0, d1);
    endtask

    task automatic wait_k(input int target);
        int n = 0;
        while (k < target && n < 3000) begin @(negedge clk); n++; end
        if (k < target) chk("timeout_wait_k", k, target);
    endtask

    task automatic wait_obs(input int target);
        int n = 0;
        while (obs1.size() < target && n < 3000) begin @(negedge clk); n++; end
        if (obs1.size() < target) chk("timeout_wait_obs", obs1.size(), target);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (m_run && n < 200) begin @(negedge clk); n++; end
        if (m_run) chk("timeout_wait_idle", m_run, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; pcm_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int EXP0[4] = '{0, 1, 0, 1};
    int EXP1[4] = '{0, 1, 1, 1};

    initial begin : stimulus
        int n, cnt, target, ufb;
        logic [31:0] r;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("reset_pdm_clk", pdm_clk, 0);
        chk("reset_pcm_ready", pcm_ready, 1);
        rst = 1'b0;

        // Channel split and clock shape
        obs0.delete(); obs1.delete();
        send(16'h0000, 16'h7FFF);
        enable = 1'b1;
        n = 0;
        while (pdm_clk !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("first_rise_delay", n, CD + 1);
        n = 0;
        while (pdm_clk === 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("high_half_len", n, CD);
        n = 0;
        while (pdm_clk === 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("low_half_len", n, CD);
        wait_obs(4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("split_ch0_%0d", i), obs0[i], EXP0[i]);
            chk($sformatf("split_ch1_%0d", i), obs1[i], EXP1[i]);
        end
        enable = 1'b0;
        wait_idle();

        // Extremes over 64 periods
        do_reset();
        obs0.delete(); obs1.delete();
        send(16'h8000, 16'h7FFF);
        enable = 1'b1;
        wait_obs(64);
        cnt = 0;
        for (int i = 0; i < 64; i++) cnt += obs0[i];
        chk("extreme_ch0_ones", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 64; i++) cnt += (obs1[i] == 0) ? 1 : 0;
        chk("extreme_ch1_zeros", cnt, 1);
        chk("extreme_ch1_first", obs1[0], 0);
        enable = 1'b0;
        wait_idle();

        // Handshake: single pair, then underrun at the second boundary
        do_reset();
        uf_cnt = 0;
        send(16'h1234, 16'hC000);
        enable = 1'b1;
        wait_k(6);
        chk("underrun_count", uf_cnt, 1);

        // Bypass load exactly on a boundary with holding empty
        target = e0 + CD + 2*CD*DEC*2;
        n = 0;
        while (cyc < target - 1 && n < 200) begin @(negedge clk); n++; end
        ufb = uf_cnt;
        offer(16'h4000, 16'hF000);
        chk("ready_after_bypass", pcm_ready, 1);
        wait_k(10);
        chk("bypass_no_underrun", uf_cnt, ufb);

        // Holding full blocks ready until the next boundary
        send(16'h0100, 16'hFF00);
        chk("ready_low_while_full", pcm_ready, 0);
        wait_k(13);
        chk("ready_after_load", pcm_ready, 1);

        // Disable during the high half, then resume
        n = 0;
        while (pdm_clk !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        enable = 1'b0;
        repeat (2*CD + 2) @(negedge clk);
        chk("disabled_pdm_clk", pdm_clk, 0);
        chk("disabled_ddr_data", ddr_data, 0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        wait_k(4);
        enable = 1'b0;
        wait_idle();

        // Randomized traffic with enable toggles
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 12)) @(negedge clk);
                enable = 1'b1;
            end
            r = $urandom();
            send(r[15:0], r[31:16]);
        end

        // Reset mid-run drops the pending sample
        send(16'h2222, 16'h3333);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_pdm_clk", pdm_clk, 0);
        chk("midrun_rst_ddr_data", ddr_data, 0);
        chk("midrun_rst_ready", pcm_ready, 1);
        chk("midrun_rst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wait_k(5);
        enable = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_dual_tx.md
# pdm_dual_tx

- Transmit-side counterpart of the dual-mic DDR-to-SDR receiver.
- Accepts signed PCM sample pairs through a valid/ready handshake and modulates each channel with a first-order sigma-delta modulator.
- Generates the PDM bit clock from `clk` and drives both channels on one shared DDR data line: channel 0 while `pdm_clk` is high, channel 1 while it is low.
- Used as a stereo PDM microphone-pair emulator for bench and loopback tests of the receive path.

## Interface
Parameters:
- `DATA_W`, 16: PCM sample width, signed two's complement.
- `CLK_DIV`, 2: `clk` cycles per `pdm_clk` half-period; must be ≥1.
- `DECIM`, 64: `pdm_clk` periods per PCM sample pair; must be ≥2.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: reset is synchronous and active-high.
- `enable`  in  1: run request; sampled only in IDLE and at period boundaries.
- `pcm_valid`  in  1: sample pair offered.
- `pcm_ready`  out  1: holding register empty.
- `pcm_data_0`  in  DATA_W: channel 0 sample.
- `pcm_data_1`  in  DATA_W: channel 1 sample.
- `pdm_clk`  out  1: generated PDM bit clock, registered.
- `ddr_data`  out  1: shared DDR PDM line, registered.
- `underrun`  out  1: one-cycle pulse when a frame starts with no new sample.

## Operation
- Reset values:
  - `pdm_clk`=0, `ddr_data`=0, `pcm_ready`=1, `underrun`=0.
  - Both accumulators=0, active samples=0, holding empty.
  - State=IDLE, all counters 0.
- Buffering: one holding register plus one active register per channel.
  - Transfer occurs when `pcm_valid`&&`pcm_ready`.
  - `pcm_ready` = !hold_full, a direct decode of the flag register.
- States:
  - IDLE: `pdm_clk` and `ddr_data` held 0; accumulators, samples and holding register retained. `enable`=1 → RUN, with div_cnt=0, phase=LOW, frame_cnt=0.
  - RUN: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 the phase toggles and div_cnt wraps.
- Rising transition (LOW→HIGH):
  - `pdm_clk`<=1.
  - Modulator steps both channels.
  - `ddr_data`<=ch0 bit; ch1 bit stored in bit1_q.
  - frame_cnt increments, wrapping DECIM-1→0.
- Falling transition (HIGH→LOW):
  - `ddr_data`<=bit1_q.
  - If `enable`=0: `pdm_clk`<=0, `ddr_data`<=0, go to IDLE. The current period always completes.
  - Otherwise `pdm_clk`<=0.
- Frame boundary (a rising transition with frame_cnt==0), evaluated in priority order:
  - Holding full: active<=holding, holding emptied.
  - Holding empty and a transfer occurs in the same cycle: input bypasses straight to active; holding stays empty; no underrun.
  - Otherwise: active unchanged (last sample repeats) and `underrun` pulses for 1 cycle.
- The modulator step always uses the post-load sample: load ? new : active.
- Modulator, per channel:
  - u = x XOR 2^(DATA_W-1) (offset binary).
  - sum = acc + u, DATA_W+1 bits.
  - bit = sum[DATA_W]; acc<=sum[DATA_W-1:0].
  - Ones density = u/2^DATA_W.
- `rst` mid-operation: all state returns to reset values on the next edge, including any pending holding sample, which is dropped.

## Timing
- Each `pdm_clk` half-period is exactly CLK_DIV `clk` cycles.
  - Period = 2·CLK_DIV.
  - First rising edge occurs CLK_DIV+1 cycles after the cycle `enable` is seen high in IDLE.
- `pdm_clk` and `ddr_data` change on the same `clk` edge.
  - ch0 bit is stable for the entire high half; ch1 bit for the entire low half.
- The sample accepted before a frame boundary first affects the bit emitted at that boundary's rising transition: zero extra latency.
- Throughput: one sample pair per DECIM·2·CLK_DIV `clk` cycles. `pcm_ready` returns to 1 on the cycle after a boundary load.
- `underrun` is asserted only on the rising-transition cycle. It never asserts in IDLE.

## Test plan
- Reset: hold `rst` 3 cycles → `pdm_clk`=0, `ddr_data`=0, `pcm_ready`=1, `underrun`=0. Reassert `rst` mid-RUN → same values on the next edge.
- Clock shape (CLK_DIV=2): `enable`=1 → `pdm_clk` has period 4 with 50% duty; first rise is 3 cycles after `enable` is sampled.
- Channel split: write ch0=0x0000 and ch1=0x7FFF before the first rise.
  - ch0 bits (`ddr_data` while high) = 0,1,0,1,…
  - ch1 bits (while low) = 0,1,1,1,…
- Extremes: ch0=0x8000 and ch1=0x7FFF for 64 periods → ch0 all zeros; ch1 has exactly one 0 (the first bit).
- Handshake/underrun (DECIM=4):
  - Supply one pair only → second boundary pulses `underrun` once and the pair repeats.
  - Offer `pcm_valid` exactly on a boundary with holding empty → bypass load, no `underrun`.
  - Holding full → `pcm_ready`=0 until the next boundary.
- Disable: drop `enable` mid high-half → the period finishes, the falling transition occurs, then IDLE with lines at 0. Re-enable → accumulators resume from their retained values.
